// File: rtl/systolic_ctrl.sv
// systolic_ctrl: tile sequencer for an ARRAY_N x ARRAY_N systolic array.
// It loads a weight tile, pulses the per-row switch, streams skewed input
// vectors into the west edge and counts results until the tile completes.
module systolic_ctrl #(
  parameter int ARRAY_N  = 2,
  parameter int MAX_ROWS = 16,
  parameter int ROW_W    = $clog2(MAX_ROWS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ROW_W-1:0]              cfg_rows,
  output logic                          busy,
  output logic                          done,
  output logic                          w_rd_en,
  output logic [$clog2(ARRAY_N)-1:0]    w_rd_addr,
  input  logic [16*ARRAY_N-1:0]         w_rd_data,
  output logic                          x_rd_en,
  output logic [$clog2(MAX_ROWS)-1:0]   x_rd_addr,
  input  logic [16*ARRAY_N-1:0]         x_rd_data,
  output logic                          arr_accept_w,
  output logic [16*ARRAY_N-1:0]         arr_weight,
  output logic [ARRAY_N-1:0]            arr_switch,
  output logic [16*ARRAY_N-1:0]         arr_input,
  output logic [ARRAY_N-1:0]            arr_valid,
  input  logic                          arr_res_valid
);

  localparam int WA_W = $clog2(ARRAY_N);
  localparam int XA_W = $clog2(MAX_ROWS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_busy;
  logic              r_done;
  logic              w_done_nxt;
  logic [ROW_W-1:0]  r_m;
  logic              r_w_rd_en;
  logic [WA_W-1:0]   r_w_rd_addr;
  logic              r_accept;
  logic [ARRAY_N-1:0] r_sw;
  logic              r_x_rd_en;
  logic [XA_W-1:0]   r_x_rd_addr;
  logic              r_xv_d;
  logic [ROW_W-1:0]  r_out_cnt;
  logic [ROW_W-1:0]  r_res_cnt;

  logic              w_cfg_ok;
  logic              w_accept;
  logic              w_last_w;
  logic              w_last_x;
  logic              w_last_valid;
  logic              w_res_done;

  assign w_cfg_ok     = (cfg_rows != '0) && (cfg_rows <= ROW_W'(MAX_ROWS));
  // The done cycle is already IDLE; holding off start there makes the
  // earliest restart the cycle after done.
  assign w_accept     = (r_state == S_IDLE) && !r_done && start && w_cfg_ok;
  // Last accept cycle: accept still high, reads already finished.
  assign w_last_w     = r_accept && !r_w_rd_en;
  assign w_last_x     = r_x_rd_en && (ROW_W'(r_x_rd_addr) == (r_m - ROW_W'(1)));
  assign w_last_valid = arr_valid[ARRAY_N-1] && (r_out_cnt == (r_m - ROW_W'(1)));
  assign w_res_done   = (r_res_cnt == r_m) ||
                        (arr_res_valid && (r_res_cnt == (r_m - ROW_W'(1))));

  // Next-state and completion decode.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_LOAD;
      S_LOAD:   if (w_last_w) w_state_nxt = S_STREAM;
      S_STREAM: if (w_last_valid) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (w_res_done) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register, read sequencing, switch pulses and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_m         <= '0;
      r_w_rd_en   <= 1'b0;
      r_w_rd_addr <= '0;
      r_accept    <= 1'b0;
      r_sw        <= '0;
      r_x_rd_en   <= 1'b0;
      r_x_rd_addr <= '0;
      r_xv_d      <= 1'b0;
      r_out_cnt   <= '0;
      r_res_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;

      if (w_accept) begin
        r_busy <= 1'b1;
        r_m    <= cfg_rows;
      end else if (r_done) begin
        r_busy <= 1'b0;
      end

      if (w_accept) begin
        r_w_rd_en   <= 1'b1;
        r_w_rd_addr <= WA_W'(ARRAY_N - 1);
      end else if (r_w_rd_en) begin
        if (r_w_rd_addr == '0) r_w_rd_en <= 1'b0;
        else                   r_w_rd_addr <= r_w_rd_addr - WA_W'(1);
      end

      r_accept <= r_w_rd_en;
      r_sw     <= {r_sw[ARRAY_N-2:0], w_last_w};

      // Input reads start right after the last weight read so that buffer
      // latency plus the row-0 register lands vector 0 at T0.
      if (r_w_rd_en && (r_w_rd_addr == '0)) begin
        r_x_rd_en   <= 1'b1;
        r_x_rd_addr <= '0;
      end else if (r_x_rd_en) begin
        if (w_last_x) begin
          r_x_rd_en   <= 1'b0;
          r_x_rd_addr <= '0;
        end else begin
          r_x_rd_addr <= r_x_rd_addr + XA_W'(1);
        end
      end
      r_xv_d <= r_x_rd_en;

      if (w_accept)                  r_out_cnt <= '0;
      else if (arr_valid[ARRAY_N-1]) r_out_cnt <= r_out_cnt + ROW_W'(1);

      if (w_accept) begin
        r_res_cnt <= '0;
      end else if ((r_state != S_IDLE) && arr_res_valid && (r_res_cnt != r_m)) begin
        r_res_cnt <= r_res_cnt + ROW_W'(1);
      end
    end
  end

  // Per-row skew: row r passes through r+1 registers after buffer data.
  for (genvar gr = 0; gr < ARRAY_N; gr++) begin : g_row
    logic [15:0] r_sk_d [gr+1];
    logic [gr:0] r_sk_v;

    // Capture row element on valid, then shift it r stages toward the edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sk_v <= '0;
        for (int unsigned s = 0; s < gr + 1; s++) r_sk_d[s] <= '0;
      end else begin
        r_sk_v[0] <= r_xv_d;
        r_sk_d[0] <= r_xv_d ? x_rd_data[16*gr +: 16] : '0;
        for (int unsigned s = 1; s < gr + 1; s++) begin
          r_sk_v[s] <= r_sk_v[s-1];
          r_sk_d[s] <= r_sk_d[s-1];
        end
      end
    end

    assign arr_input[16*gr +: 16] = r_sk_d[gr];
    assign arr_valid[gr]          = r_sk_v[gr];
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign w_rd_en      = r_w_rd_en;
  assign w_rd_addr    = r_w_rd_addr;
  assign x_rd_en      = r_x_rd_en;
  assign x_rd_addr    = r_x_rd_addr;
  assign arr_accept_w = r_accept;
  assign arr_switch   = r_sw;
  // Weight data is the buffer's registered read port forwarded in the cycle
  // it becomes valid; the registered accept gates it to zero otherwise.
  assign arr_weight   = r_accept ? w_rd_data : '0;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl (ARRAY_N=2, MAX_ROWS=16).
module tb_systolic_ctrl;

  localparam int N    = 2;
  localparam int MAXR = 16;
  localparam int RW   = $clog2(MAXR + 1);

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [RW-1:0]      cfg_rows;
  logic               busy, done;
  logic               w_rd_en;
  logic [0:0]         w_rd_addr;
  logic [32-1:0]      w_rd_data;
  logic               x_rd_en;
  logic [3:0]         x_rd_addr;
  logic [32-1:0]      x_rd_data;
  logic               arr_accept_w;
  logic [31:0]        arr_weight;
  logic [1:0]         arr_switch;
  logic [31:0]        arr_input;
  logic [1:0]         arr_valid;
  logic               arr_res_valid;

  logic [31:0] wmem [N];
  logic [31:0] xmem [MAXR];

  int n_tests = 0;
  int n_fail  = 0;
  int cur_cyc = 0;

  systolic_ctrl #(.ARRAY_N(N), .MAX_ROWS(MAXR)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows),
    .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data),
    .arr_accept_w(arr_accept_w), .arr_weight(arr_weight),
    .arr_switch(arr_switch), .arr_input(arr_input), .arr_valid(arr_valid),
    .arr_res_valid(arr_res_valid)
  );

  always #5 clk = ~clk;

  // Buffers with one-cycle read latency; garbage when not read.
  always @(posedge clk) begin
    w_rd_data <= w_rd_en ? wmem[w_rd_addr] : 32'hDEADBEEF;
    x_rd_data <= x_rd_en ? xmem[x_rd_addr] : 32'hBAADF00D;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cur_cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 128'({busy, done, w_rd_en, w_rd_addr, x_rd_en, x_rd_addr,
                     arr_accept_w, arr_switch, arr_valid}), 128'(0));
    check({tag, "_data"}, 128'({arr_weight, arr_input}), 128'(0));
  endtask

  // Expected outputs for cycle k of a tile with m vectors, done in done_k.
  task automatic check_cycle(input int k, input int m, input int done_k);
    int t0;
    logic [31:0] ew, ei;
    logic [1:0]  esw, ev;
    t0 = N + 3;
    cur_cyc = k;
    ew  = (k >= 2 && k <= N + 1) ? wmem[N + 1 - k] : 32'h0;
    esw = '0;
    ev  = '0;
    ei  = '0;
    for (int r = 0; r < N; r++) begin
      if (k == N + 2 + r) esw[r] = 1'b1;
      if (k >= t0 + r && k < t0 + r + m) begin
        ev[r] = 1'b1;
        ei[16*r +: 16] = xmem[k - t0 - r][16*r +: 16];
      end
    end
    check("busy",       128'(busy),         128'(k >= 1 && k <= done_k));
    check("done",       128'(done),         128'(k == done_k));
    check("w_rd_en",    128'(w_rd_en),      128'(k >= 1 && k <= N));
    check("w_rd_addr",  128'(w_rd_addr),    128'((k >= 1 && k <= N) ? N - k : 0));
    check("accept_w",   128'(arr_accept_w), 128'(k >= 2 && k <= N + 1));
    check("weight",     128'(arr_weight),   128'(ew));
    check("switch",     128'(arr_switch),   128'(esw));
    check("x_rd_en",    128'(x_rd_en),      128'(k >= N + 1 && k <= N + m));
    check("x_rd_addr",  128'(x_rd_addr),    128'((k >= N + 1 && k <= N + m) ? k - N - 1 : 0));
    check("arr_valid",  128'(arr_valid),    128'(ev));
    check("arr_input",  128'(arr_input),    128'(ei));
  endtask

  initial begin
    wmem[0] = {16'h000B, 16'h000A};
    wmem[1] = {16'h001B, 16'h001A};
    for (int i = 0; i < MAXR; i++) xmem[i] = {16'(2*i + 2), 16'(2*i + 1)};

    rst = 1'b1; start = 1'b0; cfg_rows = '0; arr_res_valid = 1'b0;
    tick(); tick(); tick();
    cur_cyc = 0;
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Tile A: M=3, start held high throughout, results in cycles 9..11.
    start = 1'b1; cfg_rows = RW'(3);
    for (int k = 1; k <= 13; k++) begin
      tick();
      arr_res_valid = (k >= 9 && k <= 11);
      check_cycle(k, 3, 12);
    end

    // Tile B: accepted in A's cycle 13, reset in its cycle 6.
    arr_res_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      start = 1'b0;
      check_cycle(k, 3, 1000);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cur_cyc = 7;
    check_all_zero("mid_reset");

    // Out-of-range row counts are ignored.
    start = 1'b1; cfg_rows = RW'(0);
    tick();
    cur_cyc = 1;
    check("bad0_busy",   128'({busy, w_rd_en, x_rd_en}), 128'(0));
    cfg_rows = RW'(MAXR + 1);
    tick();
    cur_cyc = 2;
    check("bad17_busy",  128'({busy, w_rd_en, x_rd_en}), 128'(0));
    start = 1'b0;
    tick();
    cur_cyc = 3;
    check("bad_idle",    128'({busy, w_rd_en, x_rd_en}), 128'(0));

    // Tile C: M=1, one result in cycle 8.
    start = 1'b1; cfg_rows = RW'(1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      start = 1'b0;
      arr_res_valid = (k == 8);
      check_cycle(k, 1, 9);
    end
    arr_res_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
